// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states and owner codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way winner select between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise DATA always wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic any_req,
    output logic winner
);

    assign any_req = if_req || d_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        winner = d_req ? OWN_D : OWN_IF;
        if (if_req && d_req)
            winner = ~last_owner;
    end
`else
    assign winner = d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and load/store ports with a bus timeout.
// Optional MEM_ARB_RR_EN switches tie-breaking from fixed DATA priority to round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            owner,
    output logic            busy
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          tmo;
    logic          hs;
    logic          any_req;
    logic          winner;
    logic          gnt_err_if;
    logic          gnt_err_d;
    logic          if_live;
    logic          d_live;
`ifdef MEM_ARB_RR_EN
    logic          last_owner;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign tmo     = (cnt_inc == CNT_MAX);
    assign hs      = (state == ST_ADDR) && m_ready;
    assign busy    = (state != ST_IDLE);

    // A request answered by an abort grant this cycle is already consumed.
    assign if_live = if_req && !gnt_err_if;
    assign d_live  = d_req && !gnt_err_d;

    assign if_gnt = (hs && owner == OWN_IF) || gnt_err_if;
    assign d_gnt  = (hs && owner == OWN_D) || gnt_err_d;

    arb_pick u_pick (
        .if_req     (if_live),
        .d_req      (d_live),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            m_valid    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
            gnt_err_if <= 1'b0;
            gnt_err_d  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= OWN_D;
`endif
        end else begin
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_err     <= 1'b0;
            d_err      <= 1'b0;
            gnt_err_if <= 1'b0;
            gnt_err_d  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        m_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_ADDR;
                        if (winner == OWN_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_wstrb <= d_wstrb;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            m_wstrb <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_RESP;
`ifdef MEM_ARB_RR_EN
                        last_owner <= owner;
`endif
                    end else if (tmo) begin
                        // Abort before acceptance: grant and error response together.
                        m_valid <= 1'b0;
                        cnt     <= cnt_inc;
                        state   <= ST_IDLE;
                        if (owner == OWN_D) begin
                            gnt_err_d <= 1'b1;
                            d_rvalid  <= 1'b1;
                            d_err     <= 1'b1;
                            d_rdata   <= '0;
                        end else begin
                            gnt_err_if <= 1'b1;
                            if_rvalid  <= 1'b1;
                            if_err     <= 1'b1;
                            if_rdata   <= '0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_owner <= owner;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RESP: begin
                    if (m_rvalid) begin
                        state <= ST_IDLE;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= m_we ? '0 : m_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= m_rdata;
                        end
                    end else if (tmo) begin
                        cnt   <= cnt_inc;
                        state <= ST_IDLE;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= 1'b1;
                            if_rdata  <= '0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          m_valid;
    logic          m_ready;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          owner;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   nchk = 0;
    int   npass = 0;
    int   gnt_cyc = 0;
    int   prev_gnt_cyc = 0;
    logic last_m;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Tie rule: fixed priority gives DATA, round-robin gives the other port.
    function automatic logic model_pick(input logic ip, input logic dp);
        if (ip && dp) begin
`ifdef MEM_ARB_RR_EN
            return ~last_m;
`else
            return 1'b1;
`endif
        end
        return dp;
    endfunction

    task automatic serve(input logic own, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int rdly, input int qdly,
                         input logic [31:0] rd);
        logic [31:0] exp_rd;
        exp_rd = (own && we) ? 32'h0 : rd;
        for (int k = 0; k <= rdly; k++) begin
            step();
            m_ready = (k == rdly);
            smp();
            chk("m_valid", m_valid, 1);
            if (k == 0) begin
                chk("m_addr", m_addr, addr);
                chk("m_we", m_we, we);
                chk("owner", owner, own);
                chk("busy", busy, 1);
                if (we) begin
                    chk("m_wdata", m_wdata, wd);
                    chk("m_wstrb", m_wstrb, ws);
                end
            end
            chk("if_gnt", if_gnt, (k == rdly) && !own);
            chk("d_gnt", d_gnt, (k == rdly) && own);
        end
        prev_gnt_cyc = gnt_cyc;
        gnt_cyc = cyc;
        last_m = own;
        for (int j = 0; j <= qdly; j++) begin
            step();
            if (j == 0) begin
                m_ready = 1'b0;
                if (own) d_req = 1'b0;
                else if_req = 1'b0;
            end
            m_rvalid = (j == qdly);
            m_rdata = (j == qdly) ? rd : $urandom;
            smp();
            chk("m_valid_resp", m_valid, 0);
            chk("rvalid_early", if_rvalid | d_rvalid, 0);
        end
        step();
        m_rvalid = 1'b0;
        m_rdata = $urandom;
        smp();
        if (own) begin
            chk("d_rvalid", d_rvalid, 1);
            chk("d_rdata", d_rdata, exp_rd);
            chk("d_err", d_err, 0);
            chk("if_rvalid_other", if_rvalid, 0);
        end else begin
            chk("if_rvalid", if_rvalid, 1);
            chk("if_rdata", if_rdata, exp_rd);
            chk("if_err", if_err, 0);
            chk("d_rvalid_other", d_rvalid, 0);
        end
        chk("busy_done", busy, 0);
    endtask

    task automatic run_pending(input int rmax, input int qmax, input logic [31:0] rd0);
        logic w;
        int   guard;
        guard = 0;
        while ((if_req || d_req) && guard < 4) begin
            guard++;
            w = model_pick(if_req, d_req);
            if (w)
                serve(1'b1, d_we, d_addr, d_wdata, d_wstrb,
                      $urandom_range(rmax, 0), $urandom_range(qmax, 0),
                      (rd0 != 0) ? rd0 : $urandom);
            else
                serve(1'b0, 1'b0, if_addr, 32'h0, 4'h0,
                      $urandom_range(rmax, 0), $urandom_range(qmax, 0),
                      (rd0 != 0) ? rd0 : $urandom);
        end
        chk("pending_drained", if_req | d_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
        last_m = 1'b1;
        step();
        step();
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_gnt", if_gnt | d_gnt, 0);
        chk("rst_rvalid", if_rvalid | d_rvalid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m_addr", m_addr, 0);
        step();
        rst = 1'b0;
        smp();

        // Single fetch, minimum latency
        step();
        if_req = 1; if_addr = 32'h100;
        smp();
        chk("t1_idle", busy, 0);
        serve(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF);

        // Fetch and load together
        step();
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        smp();
        run_pending(0, 0, 32'h0);
        chk("t2_gap", gnt_cyc - prev_gnt_cyc, 3);

        // Repeated ties
        for (int r = 0; r < 4; r++) begin
            step();
            if_req = 1; if_addr = 32'h200 + 32'(r * 4);
            d_req = 1; d_we = 0; d_addr = 32'h2100 + 32'(r * 4);
            smp();
            run_pending(0, 0, 32'h0);
        end

        // Store
        step();
        d_req = 1; d_we = 1; d_addr = 32'h3000;
        d_wdata = 32'h11223344; d_wstrb = 4'b0011;
        smp();
        run_pending(0, 0, 32'hCAFEF00D);
        d_we = 0;

        // Timeout in address phase
        step();
        if_req = 1; if_addr = 32'h500;
        smp();
        for (int k = 0; k < WM; k++) begin
            step();
            smp();
            chk("t5_m_valid", m_valid, 1);
            chk("t5_no_gnt", if_gnt | d_gnt, 0);
            chk("t5_no_rvalid", if_rvalid | d_rvalid, 0);
        end
        step();
        smp();
        chk("t5_m_valid_drop", m_valid, 0);
        chk("t5_if_gnt", if_gnt, 1);
        chk("t5_if_rvalid", if_rvalid, 1);
        chk("t5_if_err", if_err, 1);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_d_gnt", d_gnt, 0);
        last_m = 1'b0;
        step();
        if_req = 0;
        m_rvalid = 1; m_rdata = 32'h55AA55AA;
        smp();
        chk("t5_late_rvalid", if_rvalid | d_rvalid, 0);
        chk("t5_not_busy", busy, 0);
        step();
        m_rvalid = 0;
        smp();
        chk("t5_late_rvalid2", if_rvalid | d_rvalid, 0);

        // Timeout in response phase
        step();
        if_req = 1; if_addr = 32'h600;
        smp();
        step();
        m_ready = 1;
        smp();
        chk("t5b_gnt", if_gnt, 1);
        last_m = 1'b0;
        step();
        m_ready = 0; if_req = 0;
        smp();
        chk("t5b_wait", if_rvalid, 0);
        for (int k = 1; k < WM; k++) begin
            step();
            smp();
            chk("t5b_wait", if_rvalid, 0);
        end
        step();
        smp();
        chk("t5b_rvalid", if_rvalid, 1);
        chk("t5b_err", if_err, 1);
        chk("t5b_rdata", if_rdata, 0);
        chk("t5b_no_gnt", if_gnt, 0);

        // Reset during response phase
        step();
        d_req = 1; d_we = 0; d_addr = 32'h700;
        smp();
        step();
        m_ready = 1;
        smp();
        chk("t6_gnt", d_gnt, 1);
        step();
        m_ready = 0; d_req = 0;
        #2;
        rst = 1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_m_addr", m_addr, 0);
        chk("t6_rvalid", if_rvalid | d_rvalid, 0);
        step();
        rst = 0;
        last_m = 1'b1;
        m_rvalid = 1; m_rdata = 32'h12345678;
        smp();
        chk("t6_stale", if_rvalid | d_rvalid, 0);
        step();
        m_rvalid = 0;
        smp();
        chk("t6_stale2", if_rvalid | d_rvalid, 0);
        chk("t6_idle", busy, 0);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            int mask;
            mask = $urandom_range(3, 1);
            step();
            if_addr = $urandom;
            d_we = 1'($urandom);
            d_addr = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
            if_req = mask[0];
            d_req = mask[1];
            smp();
            chk("rnd_idle", busy, 0);
            run_pending(3, 3, 32'h0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
